// File: rtl/mult_tdm_sched_if.sv
// Channel-request, multiplier and result bus of the TDM multiplier scheduler.
// The slave modport is the scheduler; the master side owns the sources, the multiplier and the consumers.
interface mult_tdm_sched_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int CW    = $clog2(N_CH)
);
  logic [N_CH-1:0]            req_valid;
  logic [N_CH-1:0][WIDTH-1:0] req_a;
  logic [N_CH-1:0][WIDTH-1:0] req_b;
  logic [N_CH-1:0]            req_ready;
  logic [WIDTH-1:0]           mult_a;
  logic [WIDTH-1:0]           mult_b;
  logic [2*WIDTH-1:0]         mult_p;
  logic [N_CH-1:0]            res_valid;
  logic [2*WIDTH-1:0]         res_p;
  logic [CW-1:0]              res_ch;
  logic                       busy;

  modport slave (
    input  req_valid, req_a, req_b, mult_p,
    output req_ready, mult_a, mult_b, res_valid, res_p, res_ch, busy
  );

  modport master (
    output req_valid, req_a, req_b, mult_p,
    input  req_ready, mult_a, mult_b, res_valid, res_p, res_ch, busy
  );
endinterface

// File: rtl/mult_tdm_sched.sv
// Round-robin burst scheduler sharing one registered signed multiplier among N_CH channels.
// Issued beats carry a channel tag through a MULT_LAT-deep pipe to re-associate products.
module mult_tdm_sched_lane #(
  parameter int CW  = 2,
  parameter int IDX = 0
) (
  input  logic          in_burst,
  input  logic [CW-1:0] gnt,
  input  logic          fire,
  input  logic [CW-1:0] tag_ch,
  output logic          ready,
  output logic          res_hit
);
  assign ready   = in_burst && (gnt == CW'(IDX));
  assign res_hit = fire && (tag_ch == CW'(IDX));
endmodule

module mult_tdm_sched #(
  parameter int WIDTH     = 8,
  parameter int N_CH      = 4,
  parameter int BURST_LEN = 4,
  parameter int MULT_LAT  = 1,
  parameter int CW        = $clog2(N_CH)
) (
  input  logic           clk,
  input  logic           rst,
  mult_tdm_sched_if.slave bus
);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               gnt_q, gnt_d;
  logic [CW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]               beat_cnt_q, beat_cnt_d;
  logic [MULT_LAT-1:0]         vld_pipe_q, vld_pipe_d;
  logic [MULT_LAT-1:0][CW-1:0] ch_pipe_q, ch_pipe_d;
  logic [N_CH-1:0]             res_valid_q, res_valid_d;
  logic [2*WIDTH-1:0]          res_p_q, res_p_d;
  logic [CW-1:0]               res_ch_q, res_ch_d;

  logic [N_CH-1:0] ready, res_hit;
  logic [CW-1:0]   win, cand;
  logic            in_burst, acc, win_ok, tag_out;
  int              idx;

  assign in_burst = (state_q == BURST);
  assign acc      = in_burst && bus.req_valid[gnt_q];
  assign tag_out  = vld_pipe_q[MULT_LAT-1];

  // First requesting channel at or after rr_ptr, wrapping modulo N_CH.
  always_comb begin
    win_ok = 1'b0;
    win    = '0;
    idx    = 0;
    cand   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      cand = CW'(idx);
      if (!win_ok && bus.req_valid[cand]) begin
        win_ok = 1'b1;
        win    = cand;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    mult_tdm_sched_lane #(.CW(CW), .IDX(i)) u_lane (
      .in_burst (in_burst),
      .gnt      (gnt_q),
      .fire     (tag_out),
      .tag_ch   (ch_pipe_q[MULT_LAT-1]),
      .ready    (ready[i]),
      .res_hit  (res_hit[i])
    );
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: if (win_ok) begin
        state_d    = BURST;
        gnt_d      = win;
        beat_cnt_d = '0;
      end
      BURST: begin
        // A gap (no valid from the owner) closes the burst just like the last beat does.
        if (!acc || beat_cnt_q == BW'(BURST_LEN-1)) begin
          state_d  = IDLE;
          rr_ptr_d = (gnt_q == CW'(N_CH-1)) ? '0 : gnt_q + CW'(1);
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_pipe_d[0] = acc;
    ch_pipe_d[0]  = acc ? gnt_q : '0;
    for (int i = 1; i < MULT_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      ch_pipe_d[i]  = ch_pipe_q[i-1];
    end
    res_valid_d = res_hit;
    res_p_d     = tag_out ? bus.mult_p : res_p_q;
    res_ch_d    = tag_out ? ch_pipe_q[MULT_LAT-1] : res_ch_q;
  end

  // Reset clears the tag pipe so products of pre-reset beats are never reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      vld_pipe_q  <= '0;
      ch_pipe_q   <= '0;
      res_valid_q <= '0;
      res_p_q     <= '0;
      res_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      vld_pipe_q  <= vld_pipe_d;
      ch_pipe_q   <= ch_pipe_d;
      res_valid_q <= res_valid_d;
      res_p_q     <= res_p_d;
      res_ch_q    <= res_ch_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.mult_a    = acc ? bus.req_a[gnt_q] : '0;
  assign bus.mult_b    = acc ? bus.req_b[gnt_q] : '0;
  assign bus.res_valid = res_valid_q;
  assign bus.res_p     = res_p_q;
  assign bus.res_ch    = res_ch_q;
  assign bus.busy      = in_burst || (|vld_pipe_q);
endmodule

// File: tb/tb_mult_tdm_sched.sv
// Randomized and directed bench for mult_tdm_sched with a cycle-level reference scheduler
// and a scoreboard of due results keyed by acceptance cycle.
module tb_mult_tdm_sched;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int BL = 4;
  localparam int ML = 1;

  logic clk, rst;
  mult_tdm_sched_if #(.WIDTH(W), .N_CH(N)) bus ();

  mult_tdm_sched #(.WIDTH(W), .N_CH(N), .BURST_LEN(BL), .MULT_LAT(ML)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int pa, pb, pp;
    pa = int'($signed(a));
    pb = int'($signed(b));
    pp = pa * pb;
    return pp[2*W-1:0];
  endfunction

  // External registered multiplier.
  logic [2*W-1:0] mpipe [ML];
  always @(posedge clk) begin
    mpipe[0] <= prod(bus.mult_a, bus.mult_b);
    for (int i = 1; i < ML; i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.mult_p = mpipe[ML-1];

  int n_tests, n_fail, cyc;

  // Reference scheduler state and result scoreboard.
  bit             m_burst;
  int             m_gnt, m_rr, m_cnt;
  int             due_q[$];
  int             ch_q[$];
  logic [2*W-1:0] p_q[$];
  logic [2*W-1:0] last_p;
  int             last_ch;

  // Observations from DUT outputs for directed checks.
  int             obs_ch[$];
  logic [2*W-1:0] obs_p[$];
  int             grant_log[$], beats_log[$], idle_log[$];
  int             cur_beats, idle_run;
  logic [N-1:0]   prev_ready, last_ready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_res();
    logic [N-1:0] ev;
    ev = '0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      last_ch = ch_q.pop_front();
      last_p  = p_q.pop_front();
      ev[last_ch] = 1'b1;
    end
    chk("res_valid", bus.res_valid, ev);
    chk("res_p", bus.res_p, last_p);
    chk("res_ch", bus.res_ch, last_ch);
    if (bus.res_valid != 0) begin
      obs_p.push_back(bus.res_p);
      obs_ch.push_back(int'(bus.res_ch));
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N-1:0][W-1:0] a,
                      input logic [N-1:0][W-1:0] b);
    logic [N-1:0] er;
    logic [W-1:0] ea, eb;
    logic         acc, ebusy;
    int           g, win;
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    #1;
    er = '0; acc = 1'b0; ea = '0; eb = '0;
    if (m_burst) begin
      er[m_gnt] = 1'b1;
      acc = v[m_gnt];
      if (acc) begin
        ea = a[m_gnt];
        eb = b[m_gnt];
      end
    end
    ebusy = m_burst || (due_q.size() > 0 && due_q[0] <= cyc + ML);
    chk("req_ready", bus.req_ready, er);
    chk("mult_a", bus.mult_a, ea);
    chk("mult_b", bus.mult_b, eb);
    chk("busy", bus.busy, ebusy);

    last_ready = bus.req_ready;
    if (bus.req_ready == 0) begin
      if (prev_ready != 0) begin
        beats_log.push_back(cur_beats);
        idle_run = 0;
      end
      idle_run++;
    end else if (prev_ready == 0) begin
      g = -1;
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) g = i;
      grant_log.push_back(g);
      idle_log.push_back(idle_run);
      cur_beats = 0;
    end
    if ((bus.req_ready & v) != 0) cur_beats++;
    prev_ready = bus.req_ready;

    if (acc) begin
      due_q.push_back(cyc + ML + 1);
      ch_q.push_back(m_gnt);
      p_q.push_back(prod(a[m_gnt], b[m_gnt]));
    end
    if (!m_burst) begin
      if (v != 0) begin
        win = -1;
        for (int k = 0; k < N; k++)
          if (win < 0 && v[(m_rr + k) % N]) win = (m_rr + k) % N;
        m_burst = 1'b1;
        m_gnt   = win;
        m_cnt   = 0;
      end
    end else if (!acc || m_cnt == BL - 1) begin
      m_burst = 1'b0;
      m_rr    = (m_gnt + 1) % N;
    end else begin
      m_cnt++;
    end

    @(posedge clk);
    #1;
    cyc++;
    check_res();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_mult_a", bus.mult_a, 0);
    chk("rst_mult_b", bus.mult_b, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_p", bus.res_p, 0);
    chk("rst_res_ch", bus.res_ch, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 1'b0;
    m_burst = 1'b0; m_gnt = 0; m_rr = 0; m_cnt = 0;
    due_q.delete(); ch_q.delete(); p_q.delete();
    last_p = '0; last_ch = 0;
    obs_p.delete(); obs_ch.delete();
    grant_log.delete(); beats_log.delete(); idle_log.delete();
    prev_ready = '0; cur_beats = 0; idle_run = 0;
  endtask

  logic [N-1:0][W-1:0] za, ta, tb2;
  int dens;

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    za = '0;
    do_reset();

    // Single beat on ch1: -3 * 5.
    ta = za; tb2 = za;
    ta[1] = 8'hFD; tb2[1] = 8'd5;
    step(4'b0010, ta, tb2);
    chk("sb_ready_t0", last_ready, 4'b0000);
    step(4'b0010, ta, tb2);
    chk("sb_ready_t1", last_ready, 4'b0010);
    step(4'b0000, za, za);
    chk("sb_res_valid", bus.res_valid, 4'b0010);
    chk("sb_res_ch", bus.res_ch, 1);
    chk("sb_res_p", bus.res_p, 16'hFFF1);
    step(4'b0000, za, za);

    // Operand extremes on ch0 (search wraps from rr_ptr=2).
    obs_p.delete();
    ta = za; tb2 = za;
    ta[0] = 8'h80; tb2[0] = 8'h80;
    step(4'b0001, ta, tb2);
    step(4'b0001, ta, tb2);
    ta[0] = 8'h7F; tb2[0] = 8'h80;
    step(4'b0001, ta, tb2);
    ta[0] = 8'h00; tb2[0] = 8'hFF;
    step(4'b0001, ta, tb2);
    repeat (3) step(4'b0000, za, za);
    chk("ext_count", obs_p.size(), 3);
    if (obs_p.size() == 3) begin
      chk("ext_p0", obs_p[0], 16'h4000);
      chk("ext_p1", obs_p[1], 16'hC080);
      chk("ext_p2", obs_p[2], 16'h0000);
    end

    // Fairness: all channels continuously valid.
    do_reset();
    repeat (26) begin
      for (int i = 0; i < N; i++) begin
        ta[i] = W'($urandom);
        tb2[i] = W'($urandom);
      end
      step(4'b1111, ta, tb2);
    end
    repeat (4) step(4'b0000, za, za);
    chk("fair_bursts", (grant_log.size() >= 5 && beats_log.size() >= 5), 1);
    if (grant_log.size() >= 5 && beats_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("fair_grant", grant_log[i], i % N);
        chk("fair_beats", beats_log[i], BL);
        chk("fair_idle", idle_log[i], 1);
      end
    end

    // Gap end: ch2 drops valid after two beats while ch3 waits.
    do_reset();
    ta = za; tb2 = za;
    ta[2] = 8'd7; tb2[2] = 8'hF9; ta[3] = 8'd9; tb2[3] = 8'd11;
    repeat (3) step(4'b1100, ta, tb2);
    step(4'b1000, ta, tb2);
    step(4'b1100, ta, tb2);
    step(4'b1100, ta, tb2);
    repeat (3) step(4'b0000, za, za);
    chk("gap_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("gap_first", grant_log[0], 2);
      chk("gap_next", grant_log[1], 3);
    end
    if (beats_log.size() > 0) chk("gap_beats", beats_log[0], 2);
    else chk("gap_beats_logged", beats_log.size(), 1);

    // Reset one cycle after ch0 beat (4,4) is accepted.
    do_reset();
    ta = za; tb2 = za;
    ta[0] = 8'd4; tb2[0] = 8'd4;
    step(4'b0001, ta, tb2);
    step(4'b0001, ta, tb2);
    do_reset();
    repeat (5) step(4'b0000, za, za);
    chk("rst_no_result", obs_p.size(), 0);

    // Random traffic with varying request density.
    do_reset();
    dens = 50;
    for (int c = 0; c < 10000; c++) begin
      logic [N-1:0] v;
      if (c % 500 == 0) dens = $urandom_range(10, 95);
      for (int i = 0; i < N; i++) begin
        v[i]   = ($urandom_range(0, 99) < dens);
        ta[i]  = W'($urandom);
        tb2[i] = W'($urandom);
      end
      step(v, ta, tb2);
    end
    repeat (ML + 3) step(4'b0000, za, za);
    chk("rand_drained", due_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_tdm_sched.md
# mult_tdm_sched

Time-division scheduler that shares one registered signed multiplier (WIDTH×WIDTH → 2·WIDTH, one-cycle register latency) among N_CH requester channels. Each channel presents operand pairs on a valid/ready handshake. The block grants channels round-robin in bursts of up to BURST_LEN beats, drives the multiplier operands, and tags each issued beat with its channel. It returns each product on a shared result bus with a per-channel valid strobe. It sits between the burst sources and the single multiplier instance in the datapath.

## Interface
- WIDTH, 8: operand width in bits; products are 2·WIDTH.
- N_CH, 4: number of requester channels, ≥2.
- BURST_LEN, 4: maximum beats per grant, ≥1.
- MULT_LAT, 1: multiplier register latency in cycles, ≥1.
- CW, derived as $clog2(N_CH): width of the channel index.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_CH  per-channel beat valid.
- req_a  in  N_CH·WIDTH  channel i operand A at bits [i·WIDTH +: WIDTH], signed.
- req_b  in  N_CH·WIDTH  channel i operand B, same packing, signed.
- req_ready  out  N_CH  per-channel beat accept.
- mult_a  out  WIDTH  multiplier operand A.
- mult_b  out  WIDTH  multiplier operand B.
- mult_p  in  2·WIDTH  multiplier product, valid MULT_LAT cycles after its operands.
- res_valid  out  N_CH  one-hot strobe marking the channel that owns res_p this cycle.
- res_p  out  2·WIDTH  registered product.
- res_ch  out  CW  channel index of res_p.
- busy  out  1  high in BURST or while any tag is in flight.

## Operation
- FSM has two states: IDLE and BURST. Registers: state, gnt (CW), rr_ptr (CW), beat_cnt (0..BURST_LEN-1).
- In IDLE:
  - If any req_valid is high, pick the first high channel searching from rr_ptr upward, wrapping modulo N_CH.
  - Next cycle: state=BURST, gnt=winner, beat_cnt=0.
  - req_ready is all zero in IDLE.
- In BURST:
  - req_ready[gnt]=1; all other ready bits are 0.
  - A beat is accepted when req_valid[gnt] is high.
  - On acceptance: mult_a=req_a[gnt], mult_b=req_b[gnt] (combinational), and a tag {1, gnt} enters a MULT_LAT-deep shift register.
  - With no acceptance: mult_a=mult_b=0 and the tag shifts in {0, 0}.
- Burst end:
  - A burst ends when a beat is accepted with beat_cnt==BURST_LEN-1, or when req_valid[gnt] is low in a BURST cycle. The second case is a gap; it ends the burst and issues no beat.
  - Otherwise each accepted beat increments beat_cnt.
  - At burst end: state=IDLE, rr_ptr=(gnt+1) mod N_CH.
  - Every burst has one IDLE arbitration bubble before the next grant.
- Result stage:
  - When the tag exits the shift register valid, the next edge registers res_p=mult_p, res_ch=tag channel, res_valid=onehot(tag channel).
  - Otherwise res_valid=0 and res_p/res_ch hold their values.
- Products are full signed 2·WIDTH with no truncation or saturation. The scheduler passes them through unmodified.
- There is no result backpressure. Consumers must take res_p whenever res_valid is high.

## Timing
- Reset values: state=IDLE, gnt=0, rr_ptr=0, beat_cnt=0, all tags invalid, res_valid=0, res_p=0, res_ch=0. Derived outputs at reset: req_ready=0, mult_a=mult_b=0, busy=0.
- Latency: a beat accepted in cycle t produces res_valid in cycle t+MULT_LAT+1.
- Throughput: at most one beat per cycle. For a continuously valid channel that is sole requester, the sustained rate is BURST_LEN beats per BURST_LEN+1 cycles.
- First grant: req_valid rising in cycle t (from IDLE) gives req_ready in cycle t+1.
- Fairness: a channel that holds valid waits at most (N_CH-1)·(BURST_LEN+1) cycles after the current burst ends.
- BURST_LEN=1: the pattern alternates IDLE and BURST, one beat per grant.
- rr_ptr wrap: after a burst on channel N_CH-1, the search restarts at channel 0.
- A non-granted channel asserting valid mid-burst has no effect until the next IDLE.
- Reset mid-operation: in-flight tags are discarded. No res_valid may be asserted for beats issued before reset, even though mult_p may still carry their products.

## Test plan
- Single beat, WIDTH=8: ch1 sends a=-3, b=5 while others are idle. Required: ready1 in the cycle after valid; res_valid=0b0010, res_ch=1, res_p=0xFFF1, arriving MULT_LAT+1 cycles after acceptance.
- Extremes: ch0 sends (-128,-128), then (127,-128), then (0,-1). Required results in order: 0x4000, 0xC080, 0x0000.
- Fairness: all 4 channels continuously valid, BURST_LEN=4. Required: grant order 0,1,2,3,0; exactly 4 beats per burst; one idle cycle between bursts; tags match channels.
- Gap end: ch2 granted, drops valid after 2 beats while ch3 is valid. Required: the burst ends with 2 beats, rr_ptr=3, and ch3 is granted next.
- Reset mid-burst: assert rst one cycle after acceptance of ch0 beat (4,4). Required: all outputs at reset values and no res_valid ever asserted for 0x0010.
- Random: 10k random valid patterns and signed operands. Required: every accepted beat is returned exactly once, in order per channel, with the correct product and channel index.
